// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller slice:
//   - controller state enum (IDLE / ACCESS / DONE)
//   - default word width, address width and wait-state count
//   - width of the wait-state counter (large enough for 15 wait states)
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Single-port word storage for the data-memory controller. Writes happen on
// the rising clock edge when i_we is high; reads are combinational from the
// same address. The array is deliberately not reset so that its contents
// survive a controller reset.
//
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_addr   in   word address (shared by read and write)
//   i_wdata  in   word to store (data plus optional parity bit)
//   o_rdata  out  word currently stored at i_addr
// ----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int WORD_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_ctrl
// Multi-cycle data-memory controller. A single read or write request seen in
// IDLE is captured, held for WAIT_CYCLES cycles in ACCESS, completed on the
// edge leaving ACCESS, and acknowledged by a one-cycle Ready pulse in DONE.
// Stall holds the CPU pipeline while a request is being accepted or served.
// A simultaneous read and write request in IDLE is rejected with ErrOp.
//
// Optional feature (macro DMEM_PARITY_EN): one even-parity bit per stored
// word, checked on every read and reported on ParityErr. ParityFlip inverts
// the stored parity of the captured write. Without the macro ParityErr is 0
// and ParityFlip is ignored.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   MemRead     in   read request (level)
//   MemWrite    in   write request (level)
//   Addr        in   word address
//   WriteData   in   store data
//   ReadData    out  registered data of the last completed read
//   Ready       out  one-cycle completion pulse
//   Stall       out  pipeline hold request
//   ErrOp       out  one-cycle pulse for an illegal (read+write) request
//   ParityErr   out  parity failure of the last completed read
//   ParityFlip  in   corrupts the parity of the next captured write
// ----------------------------------------------------------------------------
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Ready,
    output logic              Stall,
    output logic              ErrOp,
    output logic              ParityErr,
    input  logic              ParityFlip
);

`ifdef DMEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_isWrite;
    logic [DATA_W-1:0] r_readData;
    logic              r_errOp;
    logic              w_oneReq;
    logic              w_bothReq;
    logic              w_accept;
    logic              w_finish;
    logic              w_we;
    logic [WORD_W-1:0] w_memWord;
    logic [WORD_W-1:0] w_memRdata;

    assign w_oneReq  = MemRead ^ MemWrite;
    assign w_bothReq = MemRead & MemWrite;
    assign w_accept  = (r_state == IDLE) && w_oneReq;
    assign w_finish  = (r_state == ACCESS) && (r_cnt == '0);

    // An access aborted by reset must not commit its write, so the array
    // enable is qualified with rst_n on the very edge that would complete it.
    assign w_we = w_finish && r_isWrite && rst_n;

    // Next state and the combinational handshake outputs.
    always_comb begin
        w_nextState = r_state;
        Stall       = 1'b0;
        Ready       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_oneReq) begin
                    w_nextState = ACCESS;
                    Stall       = 1'b1;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                if (r_cnt == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                Ready       = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Wait counter, load-data register and illegal-request flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_readData <= '0;
            r_errOp    <= 1'b0;
        end else begin
            r_errOp <= (r_state == IDLE) && w_bothReq;
            if (w_accept) begin
                r_cnt <= CNT_W'(WAIT_CYCLES - 1);
            end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish && !r_isWrite) begin
                r_readData <= w_memRdata[DATA_W-1:0];
            end
        end
    end

    // The request is captured once in IDLE; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr    <= Addr;
            r_wdata   <= WriteData;
            r_isWrite <= MemWrite;
        end
    end

`ifdef DMEM_PARITY_EN
    logic r_flip;
    logic r_parityErr;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_flip <= ParityFlip;
        end
    end

    // Even parity: the stored bit makes the XOR of the whole word zero,
    // so any non-zero XOR on readback is a parity failure.
    assign w_memWord = {(^r_wdata) ^ r_flip, r_wdata};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parityErr <= 1'b0;
        end else if (w_finish && !r_isWrite) begin
            r_parityErr <= ^w_memRdata;
        end
    end

    assign ParityErr = r_parityErr;
`else
    logic w_unusedFlip;
    assign w_unusedFlip = ParityFlip;
    assign w_memWord    = r_wdata;
    assign ParityErr    = 1'b0;
`endif

    assign ReadData = r_readData;
    assign ErrOp    = r_errOp;

    dmem_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata (w_memWord),
        .o_rdata (w_memRdata)
    );

endmodule
